ram_block_mover: RTL

Sequencing initiator for the RAMn memory chips: it drives the address, data and load pins of one RAM512-class memory to perform block copies and block fills, so a datapath can move or clear a region with a single start pulse. It sits between the CPU-side control logic and the RAM's single read/write port, and owns that port while busy. Reads use the RAM's combinational output; writes commit on the following clock edge.

---
 rtl/ram_block_mover_pkg.sv | 17 +
 rtl/ram_block_mover.sv | 115 +++++++++++
 2 files changed

// File: rtl/ram_block_mover_pkg.sv
// Shared widths, FSM state encoding and mode constants for the RAM block mover.
package ram_block_mover_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_block_mover.sv
// Block copy / block fill sequencer owning the single read/write port of a RAM512.
// Copies run read-then-write per word in ascending order; fills write one word per cycle.
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int ADDR_W = ram_block_mover_pkg::ADDR_W,
  parameter int DATA_W = ram_block_mover_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output state_t            state_dbg
);

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE_COPY;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      fill_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      fill_q      <= fill_d;
      data_q      <= data_d;
    end
  end

  // Outputs depend only on registered state, so an async reset drops ram_load at once.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    fill_d      = fill_q;
    data_d      = data_q;
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          src_ptr_d   = src;
          dst_ptr_d   = dst;
          remaining_d = len;
          fill_d      = fill_value;
          if (len == '0)
            state_d = DONE;
          else if (mode == MODE_FILL)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        ram_address = src_ptr_q;
        data_d      = ram_out;
        src_ptr_d   = src_ptr_q + 1'b1;
        state_d     = WRITE;
      end
      WRITE: begin
        ram_address = dst_ptr_q;
        ram_in      = (mode_q == MODE_FILL) ? fill_q : data_q;
        ram_load    = 1'b1;
        dst_ptr_d   = dst_ptr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == 1)
          state_d = DONE;
        else if (mode_q == MODE_FILL)
          state_d = WRITE;
        else
          state_d = READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule
